// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: per-instruction sequencer for the RV64 core.
// Owns the PC, the instruction/data memory handshakes and the
// IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> WB state machine, and keeps
// the cycle and retired-instruction counters. Environment calls and faults
// park the core in HALT until reset.
`timescale 1ns/1ps

module multi_cycle_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned MEM_TIMEOUT = 255  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory handshake
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  // decoder unit enables and opcode class
  input  logic        alu_en,
  input  logic        mem_en,
  input  logic        env_en,
  input  logic        logic_jump_en,
  input  logic        uimm_op_en,
  input  logic        S_memstore,
  input  logic        B_branch,
  input  logic        jump_taken,
  input  logic [63:0] jump_target,
  // data memory handshake
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  // write strobes and status
  output logic        rf_we,
  output logic        pc_we,
  output logic [63:0] pc,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;
  localparam logic [1:0] ERR_MISALIGN = 2'd3;

  // Last wait count that is still tolerated; the next non-ack cycle faults.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [63:0] pc_plus4;
  logic        any_en;
  logic        jump_redirect;

  assign pc_plus4      = pc + 64'd4;  // wraps modulo 2^64
  assign any_en        = alu_en | mem_en | env_en | logic_jump_en | uimm_op_en;
  assign jump_redirect = logic_jump_en & jump_taken;

  // Requests and strobes are decoded from the registered state, so an
  // asynchronous reset into IDLE drops them in the same instant.
  assign imem_req = (state == ST_FETCH);
  assign dmem_req = (state == ST_MEM);
  assign dmem_we  = dmem_req & S_memstore;
  assign rf_we    = (state == ST_WB) & ~B_branch;
  assign halted   = (state == ST_HALT);
  // NOTE: ir_we and the store-completion pc_we depend on the live ack; they
  // must see the ack in the same cycle so the edge that samples it also writes.
  assign ir_we    = imem_req & imem_ack;
  assign pc_we    = (state == ST_WB) | (dmem_we & dmem_ack);

  // Sequencer: state, PC, memory wait counter, fault code and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      wait_cnt    <= '0;
      err_code    <= ERR_NONE;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      // NOTE: every register here is updated with <= so all reads in this
      // block see the pre-edge values, independent of statement order.
      if (state != ST_IDLE && state != ST_HALT) cycle_cnt <= cycle_cnt + 64'd1;

      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          state    <= ST_FETCH;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            state <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ST_HALT;
            err_code <= ERR_BUS;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_DECODE: begin
          if (!any_en) begin
            state    <= ST_HALT;
            err_code <= ERR_ILLEGAL;
          end else begin
            state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (env_en) begin
            // Environment call retires and stops cleanly.
            state       <= ST_HALT;
            err_code    <= ERR_NONE;
            instret_cnt <= instret_cnt + 64'd1;
          end else if (mem_en) begin
            state    <= ST_MEM;
            wait_cnt <= '0;
          end else if (jump_redirect && jump_target[1:0] != 2'b00) begin
            state    <= ST_HALT;
            err_code <= ERR_MISALIGN;
          end else begin
            state <= ST_WB;
          end
        end

        ST_MEM: begin
          if (dmem_ack) begin
            if (S_memstore) begin
              // Stores have nothing to write back; retire straight from MEM.
              pc          <= pc_plus4;
              instret_cnt <= instret_cnt + 64'd1;
              wait_cnt    <= '0;
              state       <= ST_FETCH;
            end else begin
              state <= ST_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ST_HALT;
            err_code <= ERR_BUS;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_WB: begin
          pc          <= jump_redirect ? jump_target : pc_plus4;
          instret_cnt <= instret_cnt + 64'd1;
          wait_cnt    <= '0;
          state       <= ST_FETCH;
        end

        ST_HALT: state <= ST_HALT;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: each instruction's expected outcome
// is queued when it is driven and popped once the controller retires or halts.
`timescale 1ns/1ps

module tb_multi_cycle_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, ir_we;
  logic        alu_en, mem_en, env_en, logic_jump_en, uimm_op_en;
  logic        S_memstore, B_branch, jump_taken;
  logic [63:0] jump_target;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we, pc_we, halted;
  logic [63:0] pc, cycle_cnt, instret_cnt;
  logic [1:0]  err_code;

  multi_cycle_ctrl #(.RESET_PC(RST_PC), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .alu_en(alu_en), .mem_en(mem_en), .env_en(env_en),
    .logic_jump_en(logic_jump_en), .uimm_op_en(uimm_op_en),
    .S_memstore(S_memstore), .B_branch(B_branch),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc(pc), .halted(halted),
    .err_code(err_code), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit alu, mem, env, lj, uimm, st, br, taken;
    logic [63:0] tgt;
    int idly, ddly;  // ack arrives after this many waiting cycles
  } instr_t;

  typedef struct {
    string       tag;
    int          cycles, rf, irwe, dreq;
    bit          dwe;
    logic [63:0] pc, instret, cyc;
    bit          halted;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input bit alu, mem, env, lj, uimm, st, br, taken,
                                input logic [63:0] tgt, input int ddly);
    instr_t i;
    i.alu = alu; i.mem = mem; i.env = env; i.lj = lj; i.uimm = uimm;
    i.st = st; i.br = br; i.taken = taken; i.tgt = tgt;
    i.idly = 0; i.ddly = ddly;
    return i;
  endfunction

  function automatic exp_t mkexp(input string tag, input int cycles, rf, irwe, dreq,
                                 input bit dwe, input logic [63:0] epc, ins, cyc,
                                 input bit hlt, input logic [1:0] err);
    exp_t e;
    e.tag = tag; e.cycles = cycles; e.rf = rf; e.irwe = irwe; e.dreq = dreq;
    e.dwe = dwe; e.pc = epc; e.instret = ins; e.cyc = cyc; e.halted = hlt; e.err = err;
    return e;
  endfunction

  task automatic drive(input instr_t in);
    alu_en = in.alu; mem_en = in.mem; env_en = in.env; logic_jump_en = in.lj;
    uimm_op_en = in.uimm; S_memstore = in.st; B_branch = in.br;
    jump_taken = in.taken; jump_target = in.tgt;
  endtask

  // Hold reset across one rising edge, check reset values, release on a falling edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    check({tag, "/pc"}, pc, RST_PC);
    check({tag, "/strobes"}, {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we}, '0);
    check({tag, "/status"}, {halted, err_code}, '0);
    check({tag, "/counters"}, cycle_cnt | instret_cnt, '0);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from its FETCH cycle until it retires or halts.
  task automatic run_and_check(input instr_t in, input exp_t e);
    int   fw, mw, cycles, rf, irwe, dreq;
    bit   dwe, done, hlt;
    exp_t x;
    sb.push_back(e);
    drive(in);
    fw = 0; mw = 0; cycles = 0; rf = 0; irwe = 0; dreq = 0;
    dwe = 0; done = 0; hlt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (halted) begin
        done = 1; hlt = 1;
        break;
      end
      imem_ack = imem_req && (fw == in.idly);
      dmem_ack = dmem_req && (mw == in.ddly);
      if (imem_req) fw++;
      if (dmem_req) begin
        mw++; dreq++;
        if (dmem_we) dwe = 1;
      end
      #1;
      cycles++;
      if (rf_we) rf++;
      if (ir_we) irwe++;
      if (pc_we) begin
        done = 1;
        break;
      end
    end
    // Let the retiring edge land before reading architectural state.
    if (done && !hlt) begin
      @(posedge clk);
      #1;
    end
    x = sb.pop_front();
    check({x.tag, "/done"}, 64'(done), 64'd1);
    check({x.tag, "/cycles"}, 64'(cycles), 64'(x.cycles));
    check({x.tag, "/rf_we"}, 64'(rf), 64'(x.rf));
    check({x.tag, "/ir_we"}, 64'(irwe), 64'(x.irwe));
    check({x.tag, "/dmem_req"}, 64'(dreq), 64'(x.dreq));
    check({x.tag, "/dmem_we"}, 64'(dwe), 64'(x.dwe));
    check({x.tag, "/pc"}, pc, x.pc);
    check({x.tag, "/instret"}, instret_cnt, x.instret);
    check({x.tag, "/cycle_cnt"}, cycle_cnt, x.cyc);
    check({x.tag, "/halted"}, 64'(halted), 64'(x.halted));
    check({x.tag, "/err"}, 64'(err_code), 64'(x.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    instr_t add_i, ld_i, to_i;
    int     mem_seen;
    logic [63:0] frozen;

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 0));
    do_reset("reset0");

    add_i = mk(1, 0, 0, 0, 0, 0, 0, 0, 64'd0, 0);
    run_and_check(add_i, mkexp("add", 4, 1, 1, 0, 0, 64'h8000_0004, 1, 4, 0, 0));
    run_and_check(mk(0, 0, 0, 1, 0, 0, 1, 1, 64'h8000_0100, 0),
                  mkexp("branch", 4, 0, 1, 0, 0, 64'h8000_0100, 2, 8, 0, 0));
    run_and_check(mk(1, 1, 0, 0, 0, 0, 0, 0, 64'd0, 3),
                  mkexp("load", 8, 1, 1, 4, 0, 64'h8000_0104, 3, 16, 0, 0));
    run_and_check(mk(1, 1, 0, 0, 0, 1, 0, 0, 64'd0, 3),
                  mkexp("store", 7, 0, 1, 4, 1, 64'h8000_0108, 4, 23, 0, 0));
    run_and_check(mk(1, 0, 0, 1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0),
                  mkexp("jal_top", 4, 1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 5, 27, 0, 0));
    run_and_check(mk(0, 0, 0, 0, 1, 0, 0, 0, 64'd0, 0),
                  mkexp("pc_wrap", 4, 1, 1, 0, 0, 64'd0, 6, 31, 0, 0));
    run_and_check(mk(0, 0, 0, 1, 0, 0, 1, 1, 64'h8000_0102, 0),
                  mkexp("misalign", 3, 0, 1, 0, 0, 64'd0, 6, 34, 1, 3));

    // HALT is absorbing: counters and code stay frozen, no requests.
    repeat (3) @(negedge clk);
    frozen = 64'd34;
    check("halt/cycle_frozen", cycle_cnt, frozen);
    check("halt/err_frozen", 64'(err_code), 64'd3);
    check("halt/reqs", {imem_req, dmem_req, rf_we, pc_we}, '0);

    do_reset("reset1");
    to_i = add_i;
    to_i.idly = 255;
    run_and_check(to_i, mkexp("imem_timeout", 4, 0, 0, 0, 0, RST_PC, 0, 4, 1, 2));
    check("imem_timeout/req_low", 64'(imem_req), 64'd0);

    do_reset("reset2");
    run_and_check(mk(0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 0),
                  mkexp("illegal", 2, 0, 1, 0, 0, RST_PC, 0, 2, 1, 1));

    do_reset("reset3");
    run_and_check(mk(0, 0, 1, 0, 0, 0, 0, 0, 64'd0, 0),
                  mkexp("ecall", 3, 0, 1, 0, 0, RST_PC, 1, 3, 1, 0));

    do_reset("reset4");
    run_and_check(add_i, mkexp("add_pre", 4, 1, 1, 0, 0, 64'h8000_0004, 1, 4, 0, 0));

    // Load whose data never arrives; reset lands in its second MEM cycle.
    ld_i = mk(1, 1, 0, 0, 0, 0, 0, 0, 64'd0, 255);
    drive(ld_i);
    mem_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      if (dmem_req) begin
        mem_seen++;
        if (mem_seen == 2) break;
      end
    end
    check("midmem/reached", 64'(mem_seen), 64'd2);
    rst_n = 1'b0;
    #1;
    check("midmem/dmem_req", 64'(dmem_req), 64'd0);
    check("midmem/strobes", {imem_req, ir_we, rf_we, pc_we, dmem_we}, '0);
    check("midmem/pc", pc, RST_PC);
    check("midmem/counters", cycle_cnt | instret_cnt, '0);
    do_reset("reset5");
    run_and_check(add_i, mkexp("add_post", 4, 1, 1, 0, 0, 64'h8000_0004, 1, 4, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
